// File: rtl/state_announcement_decoder.sv
// Receive-side decoder for the one-hot state-announcement bus of the atomic-clock FSM.
// Deglitches the 10-bit word, decodes it to a 4-bit state code, and reports state
// changes, dwell time in the current state, and illegal (non-one-hot) words.
module state_announcement_decoder #(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned DWELL_W       = 16,
    parameter int unsigned ERRCNT_W      = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [9:0]          i_state_announcement,
    input  logic                i_err_clear,
    output logic [3:0]          o_state,
    output logic                o_state_valid,
    output logic [3:0]          o_prev_state,
    output logic                o_state_change,
    output logic [DWELL_W-1:0]  o_dwell_count,
    output logic                o_onehot_err,
    output logic                o_err_sticky,
    output logic [ERRCNT_W-1:0] o_err_count
);

    // Run counter holds up to STABLE_CYCLES+1 (at most 16), so 5 bits always suffice.
    localparam int unsigned       RUN_W    = 5;
    localparam logic [RUN_W-1:0]  RUN_QUAL = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STABLE_CYCLES + 1);

    logic [9:0]          r_s_reg;
    logic [RUN_W-1:0]    r_run;
    logic [3:0]          r_state;
    logic                r_state_valid;
    logic [3:0]          r_prev_state;
    logic                r_state_change;
    logic [DWELL_W-1:0]  r_dwell;
    logic                r_onehot_err;
    logic                r_err_sticky;
    logic [ERRCNT_W-1:0] r_err_count;

    logic [3:0]          w_ones;
    logic [3:0]          w_code;
    logic                w_legal;
    logic                w_qualify;
    logic                w_accept;
    logic                w_illegal;

    // Count set bits of the sampled word and capture the index of the set bit.
    always_comb begin
        w_ones = 4'd0;
        w_code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_s_reg[i]) begin
                w_ones = w_ones + 4'd1;
                w_code = 4'(i);
            end
        end
    end

    // The run counter hits RUN_QUAL exactly once per stable episode, so this fires once.
    assign w_legal   = (w_ones == 4'd1);
    assign w_qualify = (r_run == RUN_QUAL);
    assign w_accept  = w_qualify && w_legal && (!r_state_valid || (w_code != r_state));
    assign w_illegal = w_qualify && !w_legal;

    // Sample the bus and track how long the sampled word has been stable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_reg <= 10'd0;
            r_run   <= '0;
        end else begin
            r_s_reg <= i_state_announcement;
            if ((r_run == '0) || (i_state_announcement != r_s_reg)) begin
                r_run <= RUN_W'(1);
            end else if (r_run != RUN_MAX) begin
                r_run <= r_run + RUN_W'(1);
            end
        end
    end

    // Accept legal state changes and run the saturating dwell counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= 4'd0;
            r_prev_state   <= 4'd0;
            r_state_valid  <= 1'b0;
            r_state_change <= 1'b0;
            r_dwell        <= '0;
        end else begin
            r_state_change <= w_accept;
            if (w_accept) begin
                r_state       <= w_code;
                r_prev_state  <= r_state;
                r_state_valid <= 1'b1;
                r_dwell       <= '0;
            end else if (r_state_valid && (r_dwell != '1)) begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // Flag illegal words; a qualified illegal word takes priority over a clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_onehot_err <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_onehot_err <= w_illegal;
            if (w_illegal) begin
                r_err_sticky <= 1'b1;
                if (i_err_clear) begin
                    r_err_count <= ERRCNT_W'(1);
                end else if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end else if (i_err_clear) begin
                r_err_sticky <= 1'b0;
                r_err_count  <= '0;
            end
        end
    end

    assign o_state        = r_state;
    assign o_state_valid  = r_state_valid;
    assign o_prev_state   = r_prev_state;
    assign o_state_change = r_state_change;
    assign o_dwell_count  = r_dwell;
    assign o_onehot_err   = r_onehot_err;
    assign o_err_sticky   = r_err_sticky;
    assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_state_announcement_decoder.sv
// Directed bench for state_announcement_decoder. Expected pulse events are queued as the
// stimulus is driven and popped when the DUT pulses state_change or onehot_err.
module tb_state_announcement_decoder;

    typedef struct packed {
        logic       is_err;
        logic [3:0] state;
        logic [3:0] prev;
        logic [7:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ann;
    logic        clr;

    logic [3:0]  o_state, o_prev_state;
    logic        o_state_valid, o_state_change, o_onehot_err, o_err_sticky;
    logic [15:0] o_dwell_count;
    logic [7:0]  o_err_count;

    logic [3:0]  s2_state, s2_prev_state;
    logic        s2_state_valid, s2_state_change, s2_onehot_err, s2_err_sticky;
    logic [3:0]  s2_dwell_count;
    logic [7:0]  s2_err_count;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    state_announcement_decoder #(.STABLE_CYCLES(2), .DWELL_W(16), .ERRCNT_W(8)) u_dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_state_announcement (ann),
        .i_err_clear          (clr),
        .o_state              (o_state),
        .o_state_valid        (o_state_valid),
        .o_prev_state         (o_prev_state),
        .o_state_change       (o_state_change),
        .o_dwell_count        (o_dwell_count),
        .o_onehot_err         (o_onehot_err),
        .o_err_sticky         (o_err_sticky),
        .o_err_count          (o_err_count)
    );

    state_announcement_decoder #(.STABLE_CYCLES(2), .DWELL_W(4), .ERRCNT_W(8)) u_dut_w4 (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_state_announcement (ann),
        .i_err_clear          (clr),
        .o_state              (s2_state),
        .o_state_valid        (s2_state_valid),
        .o_prev_state         (s2_prev_state),
        .o_state_change       (s2_state_change),
        .o_dwell_count        (s2_dwell_count),
        .o_onehot_err         (s2_onehot_err),
        .o_err_sticky         (s2_err_sticky),
        .o_err_count          (s2_err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic e, input logic [3:0] s, input logic [3:0] p,
                        input logic [7:0] c);
        exp_t x;
        x.is_err = e;
        x.state  = s;
        x.prev   = p;
        x.cnt    = c;
        sb.push_back(x);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"},  32'(o_state), 32'd0);
        chk({tag, "_valid"},  32'(o_state_valid), 32'd0);
        chk({tag, "_prev"},   32'(o_prev_state), 32'd0);
        chk({tag, "_change"}, 32'(o_state_change), 32'd0);
        chk({tag, "_dwell"},  32'(o_dwell_count), 32'd0);
        chk({tag, "_err"},    32'(o_onehot_err), 32'd0);
        chk({tag, "_sticky"}, 32'(o_err_sticky), 32'd0);
        chk({tag, "_cnt"},    32'(o_err_count), 32'd0);
    endtask

    // Scoreboard: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (o_state_change || o_onehot_err) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed change=%0b err=%0b expected no pulse",
                       o_state_change, o_onehot_err);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_event", 32'({o_onehot_err, o_state, o_prev_state, o_err_count}),
                    32'(mon_e));
            end
        end
    end

    initial begin
        rst = 1'b1;
        ann = 10'd0;
        clr = 1'b0;
        tick();
        tick();
        chk_reset("rst0");

        // Reset released with Q0 on the bus: qualifies on the third edge.
        rst = 1'b0;
        ann = 10'b0000000001;
        push(1'b0, 4'd0, 4'd0, 8'd0);
        tick();
        chk("q0_e0_valid", 32'(o_state_valid), 32'd0);
        tick();
        chk("q0_e1_change", 32'(o_state_change), 32'd0);
        tick();
        chk("q0_e2_change", 32'(o_state_change), 32'd1);
        chk("q0_valid", 32'(o_state_valid), 32'd1);
        chk("q0_state", 32'(o_state), 32'd0);
        chk("q0_prev", 32'(o_prev_state), 32'd0);
        chk("q0_dwell0", 32'(o_dwell_count), 32'd0);
        tick();
        chk("q0_pulse_end", 32'(o_state_change), 32'd0);
        chk("q0_dwell1", 32'(o_dwell_count), 32'd1);
        tick();
        chk("q0_dwell2", 32'(o_dwell_count), 32'd2);
        tick();
        chk("q0_dwell3", 32'(o_dwell_count), 32'd3);

        // Q0 -> Q5.
        ann = 10'b0000100000;
        push(1'b0, 4'd5, 4'd0, 8'd0);
        tick();
        tick();
        chk("q5_early_state", 32'(o_state), 32'd0);
        chk("q5_early_dwell", 32'(o_dwell_count), 32'd5);
        tick();
        chk("q5_change", 32'(o_state_change), 32'd1);
        chk("q5_state", 32'(o_state), 32'd5);
        chk("q5_prev", 32'(o_prev_state), 32'd0);
        chk("q5_dwell0", 32'(o_dwell_count), 32'd0);
        tick();
        chk("q5_dwell1", 32'(o_dwell_count), 32'd1);

        // One-cycle glitch to bit 7 must be ignored.
        ann = 10'b0010000000;
        tick();
        ann = 10'b0000100000;
        repeat (4) tick();
        chk("glitch_state", 32'(o_state), 32'd5);
        chk("glitch_dwell", 32'(o_dwell_count), 32'd6);
        chk("glitch_err", 32'(o_err_sticky), 32'd0);

        // Two bits set: one error pulse, state held, dwell keeps counting.
        ann = 10'b0000000110;
        exp_cnt = 1;
        push(1'b1, 4'd5, 4'd0, 8'd1);
        tick();
        tick();
        chk("ill_e1_err", 32'(o_onehot_err), 32'd0);
        tick();
        chk("ill_err", 32'(o_onehot_err), 32'd1);
        chk("ill_sticky", 32'(o_err_sticky), 32'd1);
        chk("ill_cnt", 32'(o_err_count), 32'd1);
        chk("ill_state", 32'(o_state), 32'd5);
        chk("ill_valid", 32'(o_state_valid), 32'd1);
        tick();
        tick();
        chk("ill_pulse_end", 32'(o_onehot_err), 32'd0);
        chk("ill_sticky_hold", 32'(o_err_sticky), 32'd1);
        chk("ill_dwell", 32'(o_dwell_count), 32'd11);

        // Q5 -> Q9.
        ann = 10'b1000000000;
        push(1'b0, 4'd9, 4'd5, 8'd1);
        repeat (3) tick();
        chk("q9_state", 32'(o_state), 32'd9);
        chk("q9_prev", 32'(o_prev_state), 32'd5);
        chk("q9_change", 32'(o_state_change), 32'd1);

        // Clear on its own.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_cnt = 0;
        chk("clr_sticky", 32'(o_err_sticky), 32'd0);
        chk("clr_cnt", 32'(o_err_count), 32'd0);

        // Clear coinciding with an all-zero qualify: the error wins.
        ann = 10'b0000000000;
        exp_cnt = 1;
        push(1'b1, 4'd9, 4'd5, 8'd1);
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clrw_err", 32'(o_onehot_err), 32'd1);
        chk("clrw_sticky", 32'(o_err_sticky), 32'd1);
        chk("clrw_cnt", 32'(o_err_count), 32'd1);

        // 300 illegal episodes saturate the counter.
        for (int i = 0; i < 300; i++) begin
            ann = (i % 2 == 0) ? 10'b0000000011 : 10'b0000001100;
            if (exp_cnt < 255) exp_cnt++;
            push(1'b1, 4'd9, 4'd5, 8'(exp_cnt));
            repeat (3) tick();
        end
        chk("sat_cnt", 32'(o_err_count), 32'd255);
        chk("sat_state", 32'(o_state), 32'd9);

        // Reset in the middle of a qualification.
        ann = 10'b0000001000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_reset("rstmid");
        rst = 1'b0;
        push(1'b0, 4'd3, 4'd0, 8'd0);
        repeat (3) tick();
        chk("q3_change", 32'(o_state_change), 32'd1);
        chk("q3_state", 32'(o_state), 32'd3);
        chk("q3_valid", 32'(o_state_valid), 32'd1);

        // Dwell saturation on the 4-bit instance.
        repeat (14) tick();
        chk("w4_dwell14", 32'(s2_dwell_count), 32'd14);
        repeat (6) tick();
        chk("w4_dwell_sat", 32'(s2_dwell_count), 32'd15);
        chk("w16_dwell20", 32'(o_dwell_count), 32'd20);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
